// File: rtl/ahb_pkg.sv
// Shared AHB types plus the state encoding for the AHB-to-APB bridge FSM.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_trans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } ahb_size_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } ahb_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } apb_state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY get a zero-wait OKAY.
  function automatic logic trans_is_active(input ahb_trans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB slave to APB master bridge, one outstanding transfer, no write buffering.
// Define AHB2APB_PSLVERR_EN to turn pslverr into a two-cycle AHB ERROR response.
import ahb_pkg::*;

module ahb2apb_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hsel,
  input  logic [ADDR_WIDTH-1:0]  haddr,
  input  ahb_trans_t             htrans,
  input  logic                   hwrite,
  input  ahb_size_t              hsize,
  input  logic [DATA_WIDTH-1:0]  hwdata,
  input  logic                   hready,
  output logic                   hreadyout,
  output ahb_resp_t              hresp,
  output logic [DATA_WIDTH-1:0]  hrdata,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [PADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0]  pwdata,
  input  logic [DATA_WIDTH-1:0]  prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  apb_state_t             state_q, state_d;
  logic                   hreadyout_q, hreadyout_d;
  ahb_resp_t              hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;

  logic valid;
  logic apb_err;

  assign valid = hsel & hready & trans_is_active(htrans);

`ifdef AHB2APB_PSLVERR_EN
  assign apb_err = pslverr;
`else
  logic unused_pslverr;
  assign apb_err        = 1'b0;
  assign unused_pslverr = pslverr;
`endif

  // Size is not checked and the upper address bits select this bridge upstream.
  logic unused_inputs;
  assign unused_inputs = ^{hsize, haddr[ADDR_WIDTH-1:PADDR_WIDTH]};

  always_comb begin
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          paddr_d     = haddr[PADDR_WIDTH-1:0];
          pwrite_d    = hwrite;
          hreadyout_d = 1'b0;
          hresp_d     = HRESP_OKAY;
          if (hwrite) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_SETUP;
            psel_d  = 1'b1;
          end
        end
      end
      // Write data only shows up in the AHB data phase, one cycle after the address.
      ST_WDATA: begin
        pwdata_d = hwdata;
        psel_d   = 1'b1;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) begin
            hrdata_d = prdata;
          end
          if (apb_err) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            hreadyout_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      // Second ERROR cycle: hreadyout rises while hresp is still ERROR.
      ST_ERR1: begin
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_d = HRESP_OKAY;
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge with a small APB responder and transfer monitor.
import ahb_pkg::*;

module tb_ahb2apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hsel;
  logic [31:0] haddr;
  ahb_trans_t  htrans;
  logic        hwrite;
  ahb_size_t   hsize;
  logic [31:0] hwdata;
  wire         hready;
  logic        hreadyout;
  ahb_resp_t   hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  wire         pready;
  wire         pslverr;

  int   vec = 0;
  int   err = 0;
  int   pready_lat = 0;
  logic pslverr_v = 1'b0;
  int   acc_cnt;

  ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PADDR_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk_i = ~clk_i;

  // Single slave on the bus: bus hready is this slave's hreadyout.
  assign hready  = hreadyout;
  assign pready  = penable && (acc_cnt >= pready_lat);
  assign pslverr = pslverr_v;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   acc_cnt <= 0;
    else if (penable && !pready) acc_cnt <= acc_cnt + 1;
    else                         acc_cnt <= 0;
  end

  // APB monitor: cycle counts, stability violations and completed-transfer log.
  int          psel_cyc = 0;
  int          pen_cyc = 0;
  int          unstable = 0;
  int          rec_n = 0;
  logic [15:0] rec_addr [16];
  logic        rec_wr   [16];
  logic [31:0] rec_wd   [16];
  logic        psel_prev = 1'b0;
  logic [15:0] paddr_prev = '0;
  logic        pwrite_prev = 1'b0;
  logic [31:0] pwdata_prev = '0;

  always @(negedge clk_i) begin
    if (psel) psel_cyc++;
    if (penable) pen_cyc++;
    if (psel && psel_prev &&
        (paddr !== paddr_prev || pwrite !== pwrite_prev || pwdata !== pwdata_prev))
      unstable++;
    psel_prev   = psel;
    paddr_prev  = paddr;
    pwrite_prev = pwrite;
    pwdata_prev = pwdata;
    if (psel && penable && pready && rec_n < 16) begin
      rec_addr[rec_n] = paddr;
      rec_wr[rec_n]   = pwrite;
      rec_wd[rec_n]   = pwdata;
      rec_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One AHB transfer: address phase, then count data-phase cycles up to and
  // including the first cycle with hreadyout high.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input ahb_trans_t tr, output int dp_len,
                      output ahb_resp_t resp_end, output logic err_low);
    int guard;
    guard   = 0;
    err_low = 1'b0;
    @(negedge clk_i);
    hsel = 1'b1; haddr = a; hwrite = w; htrans = tr;
    while (!hready && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    @(posedge clk_i);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    dp_len = 0;
    do begin
      @(negedge clk_i);
      dp_len++;
      if (!hreadyout && hresp == HRESP_ERROR) err_low = 1'b1;
    end while (!hreadyout && dp_len < 50);
    resp_end = hresp;
    #2;
  endtask

  int        len;
  ahb_resp_t rsp;
  logic      elow;
  int        ps0, pe0, un0, r0, guard;
  int        exp_len;
  ahb_resp_t exp_resp;
  logic      exp_elow;

  initial begin
    rst_i = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hwdata = '0; prdata = '0;
    #1;
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, HRESP_OKAY);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_paddr", paddr, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Write, pready immediate
    ps0 = psel_cyc; pe0 = pen_cyc; r0 = rec_n;
    xfer(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, HTRANS_NONSEQ, len, rsp, elow);
    chk("wr_dp_len", len, 4);
    chk("wr_resp", rsp, HRESP_OKAY);
    chk("wr_psel_cyc", psel_cyc - ps0, 2);
    chk("wr_pen_cyc", pen_cyc - pe0, 1);
    chk("wr_nrec", rec_n - r0, 1);
    chk("wr_paddr", rec_addr[r0], 16'h0010);
    chk("wr_pwrite", rec_wr[r0], 1);
    chk("wr_pwdata", rec_wd[r0], 32'hDEAD_BEEF);

    // Read with three pready-low cycles
    ps0 = psel_cyc; pe0 = pen_cyc; un0 = unstable; r0 = rec_n;
    pready_lat = 3; prdata = 32'h1234_5678;
    xfer(32'h4000_0024, 1'b0, 32'h0, HTRANS_NONSEQ, len, rsp, elow);
    chk("rd_dp_len", len, 6);
    chk("rd_hrdata", hrdata, 32'h1234_5678);
    chk("rd_resp", rsp, HRESP_OKAY);
    chk("rd_psel_cyc", psel_cyc - ps0, 5);
    chk("rd_pen_cyc", pen_cyc - pe0, 4);
    chk("rd_stable", unstable - un0, 0);
    chk("rd_paddr", rec_addr[r0], 16'h0024);
    chk("rd_pwrite", rec_wr[r0], 0);
    pready_lat = 0;

    // Idle, busy and deselected transfers are ignored
    ps0 = psel_cyc;
    @(negedge clk_i);
    hsel = 1'b1; haddr = 32'h4000_0050; hwrite = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk_i);
    chk("idle_hreadyout", hreadyout, 1);
    chk("idle_psel", psel, 0);
    htrans = HTRANS_BUSY;
    @(negedge clk_i);
    chk("busy_hreadyout", hreadyout, 1);
    chk("busy_psel", psel, 0);
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(negedge clk_i);
    chk("nosel_hreadyout", hreadyout, 1);
    chk("nosel_psel", psel, 0);
    htrans = HTRANS_IDLE;
    @(negedge clk_i);
    chk("nosel_hresp", hresp, HRESP_OKAY);
    chk("ignored_psel_cyc", psel_cyc - ps0, 0);

    // Write with pslverr
`ifdef AHB2APB_PSLVERR_EN
    exp_len = 5; exp_resp = HRESP_ERROR; exp_elow = 1'b1;
`else
    exp_len = 4; exp_resp = HRESP_OKAY;  exp_elow = 1'b0;
`endif
    pslverr_v = 1'b1;
    xfer(32'h4000_0030, 1'b1, 32'hA5A5_5A5A, HTRANS_NONSEQ, len, rsp, elow);
    chk("err_dp_len", len, exp_len);
    chk("err_resp_last", rsp, exp_resp);
    chk("err_resp_low", elow, exp_elow);
    pslverr_v = 1'b0;
    @(negedge clk_i);
    chk("err_resp_after", hresp, HRESP_OKAY);
    chk("err_hreadyout_after", hreadyout, 1);

    // Read-write-read burst
    r0 = rec_n;
    prdata = 32'h1111_1111;
    xfer(32'h4000_0100, 1'b0, 32'h0, HTRANS_NONSEQ, len, rsp, elow);
    chk("b0_dp_len", len, 3);
    chk("b0_hrdata", hrdata, 32'h1111_1111);
    xfer(32'h4000_0104, 1'b1, 32'h2222_2222, HTRANS_SEQ, len, rsp, elow);
    chk("b1_dp_len", len, 4);
    chk("b1_hrdata_kept", hrdata, 32'h1111_1111);
    prdata = 32'h3333_3333;
    xfer(32'h4000_0108, 1'b0, 32'h0, HTRANS_SEQ, len, rsp, elow);
    chk("b2_hrdata", hrdata, 32'h3333_3333);
    chk("b_nrec", rec_n - r0, 3);
    chk("b0_paddr", rec_addr[r0], 16'h0100);
    chk("b0_pwrite", rec_wr[r0], 0);
    chk("b1_paddr", rec_addr[r0+1], 16'h0104);
    chk("b1_pwrite", rec_wr[r0+1], 1);
    chk("b1_pwdata", rec_wd[r0+1], 32'h2222_2222);
    chk("b2_paddr", rec_addr[r0+2], 16'h0108);
    chk("b2_pwrite", rec_wr[r0+2], 0);

    // Reset during ACCESS, then a normal transfer
    pready_lat = 20; prdata = 32'h7777_7777;
    @(negedge clk_i);
    hsel = 1'b1; haddr = 32'h4000_0200; hwrite = 1'b0; htrans = HTRANS_NONSEQ;
    @(posedge clk_i);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while (!penable && guard < 20);
    chk("rst_mid_in_access", penable, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rstm_hreadyout", hreadyout, 1);
    chk("rstm_psel", psel, 0);
    chk("rstm_penable", penable, 0);
    chk("rstm_paddr", paddr, 0);
    chk("rstm_pwdata", pwdata, 0);
    chk("rstm_hrdata", hrdata, 0);
    chk("rstm_hresp", hresp, HRESP_OKAY);
    @(negedge clk_i);
    rst_i = 1'b0; pready_lat = 0;
    r0 = rec_n;
    xfer(32'h4000_0044, 1'b1, 32'h0BAD_F00D, HTRANS_NONSEQ, len, rsp, elow);
    chk("post_rst_dp_len", len, 4);
    chk("post_rst_resp", rsp, HRESP_OKAY);
    chk("post_rst_nrec", rec_n - r0, 1);
    chk("post_rst_paddr", rec_addr[r0], 16'h0044);
    chk("post_rst_pwdata", rec_wd[r0], 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
